dmem_byte_sequencer: RTL and testbench

DMEM_BYTE_SEQUENCER -- requirements
Module: dmem_byte_sequencer

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_word_assembler.sv | 21 ++
 rtl/dmem_byte_sequencer.sv | 148 ++++++++++++++
 tb/tb_dmem_byte_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-serial data-memory sequencer.
package dmem_pkg;

  localparam int unsigned BYTES_PER_WORD     = 4;
  localparam int unsigned DMEM_DEPTH_DEFAULT = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BYTE = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_word_assembler.sv
// Little-endian byte lane helper: picks store byte k out of the word and
// merges load byte k into the partially assembled read word.
module dmem_word_assembler
  import dmem_pkg::*;
(
  input  logic [1:0]  k,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_cur,
  input  logic [7:0]  rbyte,
  output logic [7:0]  wbyte,
  output logic [31:0] rdata_next
);

  // Byte lane k occupies bits [8k+7:8k] in both directions.
  always_comb begin
    wbyte                          = wdata[{k, 3'b000} +: 8];
    rdata_next                     = rdata_cur;
    rdata_next[{k, 3'b000} +: 8]   = rbyte;
  end

endmodule

// File: rtl/dmem_byte_sequencer.sv
// Splits one MEM-stage word access into four byte accesses on a byte-wide
// data memory, freezing the pipeline until the word completes.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned or
// out-of-range requests with rsp_err instead of touching memory.
module dmem_byte_sequencer
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  localparam logic [31:0] LAST_WORD_ADDR = 32'(DEPTH - BYTES_PER_WORD);
  localparam logic [1:0]  LAST_K         = 2'(BYTES_PER_WORD - 1);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        bad_req;
  logic        in_byte;
  logic [7:0]  wbyte;
  logic [31:0] rdata_next;

  dmem_word_assembler u_asm (
    .k          (k_q),
    .wdata      (wdata_q),
    .rdata_cur  (rdata_q),
    .rbyte      (mem_rdata),
    .wbyte      (wbyte),
    .rdata_next (rdata_next)
  );

  // Handshake and request qualification; everything is gated off while reset is high.
  always_comb begin
    req_ready = !reset && (state_q == ST_IDLE);
    accept    = req_valid && req_ready;
    bad_req   = ALIGN_CHECK &&
                ((req_addr[1:0] != 2'b00) || (req_addr > LAST_WORD_ADDR));
  end

  // Next-state logic for the IDLE -> BYTE x4 -> RESP sequence.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          k_d     = '0;
          err_d   = bad_req;
          if (bad_req) begin
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_BYTE;
          end
        end
      end
      ST_BYTE: begin
        if (!write_q) begin
          rdata_d = rdata_next;
        end
        if (k_q == LAST_K) begin
          state_d = ST_RESP;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory strobes, response and stall outputs. RESP is deliberately not a
  // stalling state so the pipeline advances in the completion cycle.
  always_comb begin
    in_byte   = !reset && (state_q == ST_BYTE);
    mem_we    = in_byte && write_q;
    mem_re    = in_byte && !write_q;
    mem_addr  = in_byte ? (addr_q + 32'(k_q)) : '0;
    mem_wdata = (in_byte && write_q) ? wbyte : '0;
    rsp_valid = !reset && (state_q == ST_RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = reset ? '0 : rdata_q;
    stall     = !reset && ((state_q == ST_BYTE) ||
                           ((state_q == ST_IDLE) && req_valid));
  end

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// Self-checking bench for dmem_byte_sequencer with a byte-array memory model.
module tb_dmem_byte_sequencer;

  localparam int unsigned DEPTH = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  dmem    [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  dmem_byte_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = (mem_re && mem_addr < DEPTH) ? dmem[int'(mem_addr)] : 8'h00;

  always @(posedge clk) begin
    if (mem_we && mem_addr < DEPTH) dmem[int'(mem_addr)] <= mem_wdata;
  end

  function automatic logic [31:0] ref_word(input int unsigned a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // One complete word access with random noise on the request lines while busy.
  task automatic do_word(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL accept a=%0d: ready=%b stall=%b required 1 1", a, req_ready, stall);
    end
    if (wr) begin
      for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      exp_rd = last_rdata;
    end else begin
      exp_rd     = ref_word(a);
      last_rdata = exp_rd;
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      #1;
      vectors++;
      if (mem_we !== wr || mem_re !== !wr || mem_addr !== a + 32'(j - 1) ||
          req_ready !== 1'b0 || stall !== 1'b1 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL byte%0d: we=%b re=%b addr=%0d ready=%b stall=%b rv=%b required %b %b %0d 0 1 0",
                 j - 1, mem_we, mem_re, mem_addr, req_ready, stall, rsp_valid, wr, !wr, a + 32'(j - 1));
      end
      if (wr) begin
        vectors++;
        if (mem_wdata !== wd[8*(j-1) +: 8]) begin
          miscompares++;
          $display("FAIL wbyte%0d: got %h required %h", j - 1, mem_wdata, wd[8*(j-1) +: 8]);
        end
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
        stall !== 1'b0 || rsp_rdata !== exp_rd) begin
      miscompares++;
      $display("FAIL resp a=%0d wr=%b: rv=%b err=%b we=%b re=%b stall=%b rdata=%h required 1 0 0 0 0 %h",
               a, wr, rsp_valid, rsp_err, mem_we, mem_re, stall, rsp_rdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset = 1'b1; req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom;
      #1;
      vectors++;
      if (req_ready !== 1'b0 || stall !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
          mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 8'd0 ||
          rsp_rdata !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_hold: ready=%b stall=%b rv=%b err=%b we=%b re=%b addr=%h wd=%h rd=%h required all zero",
                 req_ready, stall, rsp_valid, rsp_err, mem_we, mem_re, mem_addr, mem_wdata, rsp_rdata);
      end
    end
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b stall=%b required 1 0", req_ready, stall);
    end
    last_rdata = 32'd0;
  endtask

  task automatic test_store_load();
    do_word(1'b1, 32'd8, 32'hDEADBEEF);
    do_word(1'b0, 32'd8, 32'd0);
    do_word(1'b1, 32'd0, 32'h01020304);
    do_word(1'b1, 32'd36, 32'hCAFEF00D);
    do_word(1'b0, 32'd36, 32'd0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      do_word(1'($urandom), 32'(4 * $urandom_range(0, DEPTH / 4 - 1)), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    b     = 32'(4 * $urandom_range(0, DEPTH / 4 - 1));
    exp_a = ref_word(8);
    exp_b = ref_word(b);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      req_valid = (c <= 10); req_write = 1'b0; req_addr = (c == 0) ? 32'd8 : b;
      #1;
      vectors++;
      if (c == 0 || c == 6) begin
        if (req_ready !== 1'b1 || stall !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_accept c=%0d: ready=%b stall=%b required 1 1", c, req_ready, stall);
        end
      end else if (c == 5 || c == 11) begin
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 ||
            stall !== 1'b0 || rsp_rdata !== ((c == 5) ? exp_a : exp_b)) begin
          miscompares++;
          $display("FAIL b2b_resp c=%0d: rv=%b ready=%b re=%b we=%b stall=%b rdata=%h required 1 0 0 0 0 %h",
                   c, rsp_valid, req_ready, mem_re, mem_we, stall, rsp_rdata, (c == 5) ? exp_a : exp_b);
        end
      end else begin
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || req_ready !== 1'b0 ||
            mem_addr !== ((c < 5) ? 32'd8 + 32'(c - 1) : b + 32'(c - 7))) begin
          miscompares++;
          $display("FAIL b2b_byte c=%0d: re=%b we=%b ready=%b addr=%0d", c, mem_re, mem_we, req_ready, mem_addr);
        end
      end
    end
    last_rdata = exp_b;
  endtask

  task automatic test_reset_mid_store();
    do_word(1'b1, 32'd8, 32'h11223344);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      reset     = (c == 3 || c == 4);
      req_valid = (c == 0); req_write = 1'b1; req_addr = 32'd8; req_wdata = 32'hDEADBEEF;
      #1;
      vectors++;
      if (c == 1 || c == 2) begin
        if (mem_we !== 1'b1 || mem_addr !== 32'(7 + c) ||
            mem_wdata !== ((c == 1) ? 8'hEF : 8'hBE)) begin
          miscompares++;
          $display("FAIL rst_pre c=%0d: we=%b addr=%0d wd=%h", c, mem_we, mem_addr, mem_wdata);
        end
      end else if (c == 3 || c == 4) begin
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 ||
            stall !== 1'b0 || rsp_rdata !== 32'd0) begin
          miscompares++;
          $display("FAIL rst_during c=%0d: we=%b re=%b rv=%b ready=%b stall=%b rd=%h required 0 0 0 0 0 0",
                   c, mem_we, mem_re, rsp_valid, req_ready, stall, rsp_rdata);
        end
      end else if (c == 5 || c == 6) begin
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL rst_after c=%0d: ready=%b rv=%b we=%b required 1 0 0", c, req_ready, rsp_valid, mem_we);
        end
      end else begin
        if (req_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rst_accept: ready=%b required 1", req_ready);
        end
      end
    end
    req_valid   = 1'b0;
    ref_mem[8]  = 8'hEF;
    ref_mem[9]  = 8'hBE;
    last_rdata  = 32'd0;
    do_word(1'b0, 32'd8, 32'd0);
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic test_align();
    logic [31:0] bad_addrs [2];
    bad_addrs[0] = 32'd6;
    bad_addrs[1] = 32'd37;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c <= 2; c++) begin
        @(negedge clk);
        req_valid = (c == 0); req_write = 1'b0; req_addr = bad_addrs[n];
        #1;
        vectors++;
        if (c == 1) begin
          if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 ||
              mem_we !== 1'b0 || mem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL align_err a=%0d: rv=%b err=%b rd=%h we=%b re=%b required 1 1 0 0 0",
                     bad_addrs[n], rsp_valid, rsp_err, rsp_rdata, mem_we, mem_re);
          end
        end else if (mem_we !== 1'b0 || mem_re !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL align_idle a=%0d c=%0d: we=%b re=%b rv=%b ready=%b required 0 0 0 1",
                   bad_addrs[n], c, mem_we, mem_re, rsp_valid, req_ready);
        end
      end
    end
    last_rdata = 32'd0;
    do_word(1'b1, 32'd36, 32'h5A5AA5A5);
  endtask
`else
  task automatic test_align();
    do_word(1'b0, 32'd6, 32'd0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    last_rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      dmem[i]    = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    test_reset();
    test_store_load();
    test_random();
    test_back_to_back();
    test_reset_mid_store();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
